// File: rtl/cmd_sequencer_if.sv
// Command-sequencer bus: memory load port, run control, UART sender handshake and status.
// The sequencer connects through the slave modport; the environment driving it uses master.
interface cmd_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int TMO_W = 24
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             ld_en;
    logic [IDX_W-1:0] ld_addr;
    logic [16:0]      ld_data;
    logic [IDX_W:0]   num_cmds;
    logic [TMO_W-1:0] tmo;
    logic             start;
    logic             snd_cmd;
    logic [15:0]      cmd;
    logic             cmd_snt;
    logic             resp_rdy;
    logic [7:0]       resp;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       err_cnt;
    logic [IDX_W:0]   cur_indx;

    modport master (
        output ld_en, ld_addr, ld_data, num_cmds, tmo, start, cmd_snt, resp_rdy, resp,
        input  snd_cmd, cmd, busy, done, err, err_cnt, cur_indx
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, num_cmds, tmo, start, cmd_snt, resp_rdy, resp,
        output snd_cmd, cmd, busy, done, err, err_cnt, cur_indx
    );
endinterface

// File: rtl/cmd_sequencer.sv
// Plays a table of 16-bit commands to a UART sender, optionally waiting for an ACK byte per command.
// Define CMD_SEQ_ABORT_EN to end the run at the first failed command instead of continuing.
module cmd_sequencer #(
    parameter int         DEPTH = 16,
    parameter int         TMO_W = 24,
    parameter logic [7:0] ACK   = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    cmd_sequencer_if.slave bus
);
    localparam int             IDX_W   = $clog2(DEPTH);
    localparam logic [IDX_W:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_SNT,
        S_WAIT_RESP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [16:0]      mem [DEPTH];
    logic [IDX_W:0]   num_reg;
    logic [IDX_W:0]   cur_indx_reg;
    logic [IDX_W:0]   cur_indx_next;
    logic [IDX_W-1:0] rd_addr;
    logic [15:0]      cmd_reg;
    logic             wait_ack_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             err_reg;
    logic [7:0]       err_cnt_reg;
    logic             tmo_hit;
    logic             fail;
    logic             phase_clr;

    assign cur_indx_next = cur_indx_reg + IDX_ONE;
    assign rd_addr       = cur_indx_reg[IDX_W-1:0];
    // A zero timeout never fires; otherwise the last permitted cycle of a phase is tmo-1.
    assign tmo_hit       = (bus.tmo != '0) && (tmo_cnt_reg == bus.tmo - TMO_W'(1));

    // Command table: writable only while idle, contents survive reset.
    always_ff @(posedge clk) begin
        if (state_reg == S_IDLE && bus.ld_en) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Registered table read; the word stays on cmd until the next LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_reg      <= '0;
            wait_ack_reg <= 1'b0;
        end else if (state_reg == S_LOAD) begin
            cmd_reg      <= mem[rd_addr][15:0];
            wait_ack_reg <= mem[rd_addr][16];
        end
    end

    always_comb begin
        state_next = state_reg;
        fail       = 1'b0;
        phase_clr  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.num_cmds == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:  state_next = S_SEND;
            S_SEND:  state_next = S_WAIT_SNT;
            S_WAIT_SNT: begin
                if (bus.cmd_snt) begin
                    phase_clr  = 1'b1;
                    state_next = wait_ack_reg ? S_WAIT_RESP : S_NEXT;
                end else if (tmo_hit) begin
                    fail       = 1'b1;
                    state_next = S_NEXT;
                end
            end
            S_WAIT_RESP: begin
                // A response arriving on the timeout cycle still counts.
                if (bus.resp_rdy) begin
                    fail       = (bus.resp != ACK);
                    state_next = S_NEXT;
                end else if (tmo_hit) begin
                    fail       = 1'b1;
                    state_next = S_NEXT;
                end
            end
            S_NEXT:  state_next = (cur_indx_next == num_reg) ? S_DONE : S_LOAD;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
`ifdef CMD_SEQ_ABORT_EN
        if (fail) begin
            state_next = S_DONE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            num_reg      <= '0;
            cur_indx_reg <= '0;
            tmo_cnt_reg  <= '0;
            err_reg      <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == S_IDLE && bus.start) begin
                num_reg      <= bus.num_cmds;
                cur_indx_reg <= '0;
                err_reg      <= 1'b0;
                err_cnt_reg  <= '0;
            end

            if (state_reg == S_NEXT) begin
                cur_indx_reg <= cur_indx_next;
            end

            // Each wait phase gets its own full timeout budget.
            if (state_reg == S_SEND || phase_clr) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == S_WAIT_SNT || state_reg == S_WAIT_RESP) begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end

            if (fail) begin
                err_reg <= 1'b1;
                if (err_cnt_reg != 8'hFF) begin
                    err_cnt_reg <= err_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign bus.snd_cmd  = (state_reg == S_SEND);
    assign bus.done     = (state_reg == S_DONE);
    assign bus.busy     = (state_reg != S_IDLE);
    assign bus.cmd      = cmd_reg;
    assign bus.err      = err_reg;
    assign bus.err_cnt  = err_cnt_reg;
    assign bus.cur_indx = cur_indx_reg;
endmodule

// File: tb/tb_cmd_sequencer.sv
// Randomized and directed bench for cmd_sequencer: a per-cycle schedule of expected outputs is
// built from the command table and planned remote-side delays, then compared every cycle.
module tb_cmd_sequencer;
    localparam int         DEPTH = 16;
    localparam int         TMO_W = 24;
    localparam int         IDX_W = 4;
    localparam int         MAXC  = 1024;
    localparam logic [7:0] ACK   = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmd_sequencer_if #(.DEPTH(DEPTH), .TMO_W(TMO_W)) bus ();

    cmd_sequencer #(.DEPTH(DEPTH), .TMO_W(TMO_W), .ACK(ACK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit               busy;
        bit               snd;
        bit               done;
        bit               err;
        int               cnt;
        int               idx;
        logic [15:0]      cmd;
        bit               snt;
        bit               rdy;
        logic [7:0]       rbyte;
        bit               st_n;
        bit               ld_n;
        logic [IDX_W-1:0] ld_a;
        logic [16:0]      ld_d;
        logic [IDX_W:0]   num_n;
    } cyc_t;

    cyc_t        sch [MAXC];
    logic [16:0] mem_m [DEPTH];
    int          p_snt [DEPTH];
    int          p_rsp [DEPTH];
    logic [7:0]  p_byte [DEPTH];
    int          m_idx, m_err, m_cnt;
    logic [15:0] m_cmd;

    int          n_vec = 0;
    int          n_mis = 0;
    int          snd_seen, done_at, busy_cycles, first_snd;
    logic [15:0] first_word;
    int          fin_err, fin_cnt, fin_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: dut=%0h model=%0h", name, act, exp);
        end
    endtask

    task automatic emit(input int t, input bit b, input bit s, input bit d);
        sch[t].busy = b;
        sch[t].snd  = s;
        sch[t].done = d;
        sch[t].err  = (m_err != 0);
        sch[t].cnt  = m_cnt;
        sch[t].idx  = m_idx;
        sch[t].cmd  = m_cmd;
    endtask

    // Cycle 0 is the cycle start is driven; each phase length follows from the planned delays.
    task automatic build_run(input int n, input int tv, input bit noise, output int tend, output int wr0);
        int t, ph, ev;
        bit fail, wa;
        for (int k = 0; k < MAXC; k++) sch[k] = '{default: '0};
        wr0 = -1;
        emit(0, 1'b0, 1'b0, 1'b0);
        m_idx = 0;
        m_err = 0;
        m_cnt = 0;
        t = 1;
        if (n == 0) begin
            emit(1, 1'b1, 1'b0, 1'b1);
            t = 2;
        end else begin
            for (int i = 0; i < n; i++) begin
                emit(t, 1'b1, 1'b0, 1'b0);
                t++;
                m_cmd = mem_m[i][15:0];
                wa    = mem_m[i][16];
                emit(t, 1'b1, 1'b1, 1'b0);
                t++;
                ev   = p_snt[i];
                fail = !(ev >= 0 && (tv == 0 || ev < tv));
                ph   = fail ? tv : ev + 1;
                for (int k = 0; k < ph; k++) begin
                    emit(t + k, 1'b1, 1'b0, 1'b0);
                    if (noise) begin
                        sch[t + k].rdy   = 1'($urandom_range(0, 1));
                        sch[t + k].rbyte = 8'($urandom);
                    end
                end
                if (!fail) sch[t + ev].snt = 1'b1;
                t += ph;
                if (!fail && wa) begin
                    if (wr0 < 0) wr0 = t;
                    ev   = p_rsp[i];
                    fail = !(ev >= 0 && (tv == 0 || ev < tv));
                    ph   = fail ? tv : ev + 1;
                    for (int k = 0; k < ph; k++) emit(t + k, 1'b1, 1'b0, 1'b0);
                    if (!fail) begin
                        sch[t + ev].rdy   = 1'b1;
                        sch[t + ev].rbyte = p_byte[i];
                        fail = (p_byte[i] != ACK);
                    end
                    t += ph;
                end
                if (fail) begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end
`ifdef CMD_SEQ_ABORT_EN
                if (fail) break;
`endif
                emit(t, 1'b1, 1'b0, 1'b0);
                t++;
                m_idx = i + 1;
            end
            emit(t, 1'b1, 1'b0, 1'b1);
            t++;
        end
        emit(t, 1'b0, 1'b0, 1'b0);
        tend = t;
        if (noise) begin
            for (int k = 1; k < tend; k++) begin
                sch[k].st_n  = ($urandom_range(0, 9) == 0);
                sch[k].ld_n  = ($urandom_range(0, 9) == 0);
                sch[k].ld_a  = IDX_W'($urandom);
                sch[k].ld_d  = 17'($urandom);
                sch[k].num_n = 5'($urandom);
            end
        end
    endtask

    task automatic run_sched(input int tend, input int n, input int tv, input int rst_at);
        snd_seen    = 0;
        done_at     = -1;
        busy_cycles = 0;
        first_snd   = -1;
        first_word  = '0;
        for (int t = 0; t <= tend; t++) begin
            @(posedge clk);
            #1;
            bus.tmo = TMO_W'(tv);
            if (rst_at >= 0 && t > rst_at) begin
                rst          = 1'b0;
                bus.start    = 1'b0;
                bus.ld_en    = 1'b0;
                bus.cmd_snt  = 1'b0;
                bus.resp_rdy = 1'b0;
                bus.resp     = '0;
            end else begin
                rst          = (t == rst_at);
                bus.start    = (t == 0) ? 1'b1 : sch[t].st_n;
                bus.num_cmds = (t == 0) ? 5'(n) : sch[t].num_n;
                bus.ld_en    = sch[t].ld_n;
                bus.ld_addr  = sch[t].ld_a;
                bus.ld_data  = sch[t].ld_d;
                bus.cmd_snt  = sch[t].snt;
                bus.resp_rdy = sch[t].rdy;
                bus.resp     = sch[t].rbyte;
            end
            @(negedge clk);
            if (rst_at >= 0 && t == rst_at + 1) begin
                chk("rst_snd_cmd", 32'(bus.snd_cmd), 32'd0);
                chk("rst_cmd", 32'(bus.cmd), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_done", 32'(bus.done), 32'd0);
                chk("rst_err", 32'(bus.err), 32'd0);
                chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
                chk("rst_cur_indx", 32'(bus.cur_indx), 32'd0);
                m_idx = 0;
                m_err = 0;
                m_cnt = 0;
                m_cmd = '0;
                return;
            end
            chk($sformatf("busy@%0d", t), 32'(bus.busy), 32'(sch[t].busy));
            chk($sformatf("snd_cmd@%0d", t), 32'(bus.snd_cmd), 32'(sch[t].snd));
            chk($sformatf("done@%0d", t), 32'(bus.done), 32'(sch[t].done));
            chk($sformatf("err@%0d", t), 32'(bus.err), 32'(sch[t].err));
            chk($sformatf("err_cnt@%0d", t), 32'(bus.err_cnt), 32'(sch[t].cnt));
            chk($sformatf("cur_indx@%0d", t), 32'(bus.cur_indx), 32'(sch[t].idx));
            chk($sformatf("cmd@%0d", t), 32'(bus.cmd), 32'(sch[t].cmd));
            if (bus.snd_cmd === 1'b1) begin
                if (first_snd < 0) begin
                    first_snd  = t;
                    first_word = bus.cmd;
                end
                snd_seen++;
            end
            if (bus.done === 1'b1 && done_at < 0) done_at = t;
            if (bus.busy === 1'b1) busy_cycles++;
        end
        fin_err = 32'(bus.err);
        fin_cnt = 32'(bus.err_cnt);
        fin_idx = 32'(bus.cur_indx);
    endtask

    task automatic load(input int a, input logic [16:0] d);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.cmd_snt  = 1'b0;
        bus.resp_rdy = 1'b0;
        bus.ld_en    = 1'b1;
        bus.ld_addr  = IDX_W'(a);
        bus.ld_data  = d;
        mem_m[a]     = d;
        @(negedge clk);
        chk("load_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic plan_fixed(input int ds, input int dr, input logic [7:0] b);
        for (int i = 0; i < DEPTH; i++) begin
            p_snt[i]  = ds;
            p_rsp[i]  = dr;
            p_byte[i] = b;
        end
    endtask

    task automatic plan_rand(input int tv);
        int lim;
        int r;
        lim = (tv == 0) ? 6 : ((tv - 1 < 6) ? tv - 1 : 6);
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 9);
            if (tv != 0 && tv <= 50 && r < 3) p_snt[i] = -1;
            else if (tv != 0 && tv <= 50 && r == 3) p_snt[i] = tv - 1;
            else p_snt[i] = $urandom_range(0, lim);
            r = $urandom_range(0, 9);
            if (tv != 0 && tv <= 50 && r < 3) p_rsp[i] = -1;
            else if (tv != 0 && tv <= 50 && r == 3) p_rsp[i] = tv - 1;
            else p_rsp[i] = $urandom_range(0, lim);
            p_byte[i] = 8'($urandom);
            if ($urandom_range(0, 3) != 0 || p_byte[i] == ACK) p_byte[i] = ACK;
        end
    endtask

    initial begin
        int tend, wr0, n, tv;
        rst          = 1'b1;
        bus.ld_en    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.num_cmds = '0;
        bus.tmo      = '0;
        bus.start    = 1'b0;
        bus.cmd_snt  = 1'b0;
        bus.resp_rdy = 1'b0;
        bus.resp     = '0;
        m_idx = 0;
        m_err = 0;
        m_cnt = 0;
        m_cmd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_snd_cmd", 32'(bus.snd_cmd), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_cmd", 32'(bus.cmd), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("reset_cur_indx", 32'(bus.cur_indx), 32'd0);
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) load(a, 17'($urandom));

        // Empty run: straight to DONE, busy only there.
        build_run(0, 0, 1'b0, tend, wr0);
        run_sched(tend, 0, 0, -1);
        chk("empty_done_at", 32'(done_at), 32'd1);
        chk("empty_busy_cycles", 32'(busy_cycles), 32'd1);
        chk("empty_snd_count", 32'(snd_seen), 32'd0);
        chk("empty_err", 32'(fin_err), 32'd0);
        $display("run empty: done_at=%0d busy_cycles=%0d", done_at, busy_cycles);

        // Two commands, cmd_snt after 50 cycles, ACK on the first.
        load(0, 17'h10000);
        load(1, 17'h04022);
        plan_fixed(50, 3, ACK);
        build_run(2, 1000, 1'b0, tend, wr0);
        run_sched(tend, 2, 1000, -1);
        chk("basic_snd_count", 32'(snd_seen), 32'd2);
        chk("basic_first_snd", 32'(first_snd), 32'd2);
        chk("basic_done_at", 32'(done_at), 32'd113);
        chk("basic_err", 32'(fin_err), 32'd0);
        chk("basic_cur_indx", 32'(fin_idx), 32'd2);
        $display("run basic: done_at=%0d snd=%0d cur=%0d", done_at, snd_seen, fin_idx);

        // Negative acknowledge.
        load(0, 17'h12002);
        plan_fixed(2, 2, 8'h5A);
        build_run(1, 1000, 1'b0, tend, wr0);
        run_sched(tend, 1, 1000, -1);
        chk("nak_err", 32'(fin_err), 32'd1);
        chk("nak_err_cnt", 32'(fin_cnt), 32'd1);
`ifdef CMD_SEQ_ABORT_EN
        chk("nak_done_at", 32'(done_at), 32'd9);
`else
        chk("nak_done_at", 32'(done_at), 32'd10);
`endif
        $display("run nak: done_at=%0d err_cnt=%0d", done_at, fin_cnt);

        // cmd_snt never arrives: every command times out.
        plan_fixed(-1, -1, ACK);
        build_run(3, 100, 1'b0, tend, wr0);
        run_sched(tend, 3, 100, -1);
`ifdef CMD_SEQ_ABORT_EN
        chk("tmo_done_at", 32'(done_at), 32'd103);
        chk("tmo_err_cnt", 32'(fin_cnt), 32'd1);
        chk("tmo_cur_indx", 32'(fin_idx), 32'd0);
`else
        chk("tmo_done_at", 32'(done_at), 32'd310);
        chk("tmo_err_cnt", 32'(fin_cnt), 32'd3);
        chk("tmo_cur_indx", 32'(fin_idx), 32'd3);
`endif
        $display("run timeout: done_at=%0d err_cnt=%0d cur=%0d", done_at, fin_cnt, fin_idx);

        // Reset while waiting for a response, then a clean re-run.
        load(0, 17'h1BEEF);
        plan_fixed(1, 30, ACK);
        build_run(2, 1000, 1'b0, tend, wr0);
        run_sched(tend, 2, 1000, wr0 + 2);
        $display("run reset: rst at cycle %0d", wr0 + 2);
        build_run(2, 1000, 1'b0, tend, wr0);
        run_sched(tend, 2, 1000, -1);
        chk("rerun_first_word", 32'(first_word), 32'h0000BEEF);
        chk("rerun_cur_indx", 32'(fin_idx), 32'd2);
        $display("run rerun: first cmd=%h cur=%0d", first_word, fin_idx);

        // Table writes during a run are dropped; after the run they land.
        load(0, 17'h01234);
        plan_fixed(1, 1, ACK);
        build_run(2, 1000, 1'b0, tend, wr0);
        sch[2].ld_n = 1'b1;
        sch[2].ld_a = '0;
        sch[2].ld_d = 17'h133F1;
        run_sched(tend, 2, 1000, -1);
        build_run(1, 1000, 1'b0, tend, wr0);
        run_sched(tend, 1, 1000, -1);
        chk("wprot_word", 32'(first_word), 32'h00001234);
        load(0, 17'h133F1);
        build_run(1, 1000, 1'b0, tend, wr0);
        run_sched(tend, 1, 1000, -1);
        chk("reload_word", 32'(first_word), 32'h000033F1);
        $display("run write-protect: cmd after reload=%h", first_word);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 3; k++) load($urandom_range(0, DEPTH - 1), 17'($urandom));
            n = $urandom_range(0, DEPTH);
            case ($urandom_range(0, 3))
                0:       tv = 0;
                1:       tv = $urandom_range(1, 4);
                2:       tv = $urandom_range(5, 12);
                default: tv = 1000;
            endcase
            plan_rand(tv);
            build_run(n, tv, 1'b1, tend, wr0);
            run_sched(tend, n, tv, -1);
            $display("run rand%0d: n=%0d tmo=%0d cycles=%0d err=%0d err_cnt=%0d cur=%0d",
                     r, n, tv, tend, fin_err, fin_cnt, fin_idx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, command-memory entries (power of 2, >=2); IDX_W = clog2(DEPTH) is local.
REQ-002 Parameter TMO_W, default 24, width of the timeout counter and of the tmo port.
REQ-003 Parameter ACK, default 8'hA5, positive-acknowledge byte.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ld_en  in  1  write ld_data into memory at ld_addr.
REQ-007 ld_addr  in  IDX_W  memory write address.
REQ-008 ld_data  in  17  [16]=wait_ack flag, [15:0]=command word.
REQ-009 num_cmds  in  IDX_W+1  entries to run, 0..DEPTH.
REQ-010 tmo  in  TMO_W  per-phase timeout in cycles; 0 disables timeout.
REQ-011 start  in  1  begin a run.
REQ-012 snd_cmd  out  1  one-cycle request to the RemoteComm-style UART sender.
REQ-013 cmd  out  16  command word, stable from LOAD until the next LOAD.
REQ-014 cmd_snt  in  1  sender finished transmitting cmd.
REQ-015 resp_rdy / resp  in  1 / 8  response-valid strobe and response byte.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at end of run.
REQ-018 err  out  1  sticky: any command failed during the current or last run.
REQ-019 err_cnt  out  8  failed-command count, saturates at 255.
REQ-020 cur_indx  out  IDX_W+1  index of the command in flight / commands completed.

Function
REQ-021 States: IDLE, LOAD, SEND, WAIT_SNT, WAIT_RESP, NEXT, DONE.
REQ-022 IDLE: ld_en writes memory; start with num_cmds>0 latches num_cmds, clears cur_indx, err, err_cnt, goes to LOAD.
REQ-023 IDLE: start with num_cmds==0 goes to DONE directly; no snd_cmd issued, err stays 0.
REQ-024 LOAD: registers mem[cur_indx] into cmd and wait_ack; one cycle; goes to SEND.
REQ-025 SEND: snd_cmd high exactly this one cycle; timeout counter cleared; goes to WAIT_SNT.
REQ-026 snd_cmd first asserts exactly 2 cycles after start is sampled high.
REQ-027 WAIT_SNT: cmd_snt -> WAIT_RESP if wait_ack, else NEXT; resp_rdy ignored here.
REQ-028 WAIT_RESP: resp_rdy with resp==ACK -> NEXT; resp_rdy with any other byte -> error, NEXT.
REQ-029 Timeout: in WAIT_SNT/WAIT_RESP the counter increments each cycle; counter==tmo-1 with no qualifying event -> error, NEXT; qualifying event in same cycle wins.
REQ-030 Error: sets err, increments err_cnt (saturating at 255).
REQ-031 NEXT: cur_indx+1; equals latched num_cmds -> DONE, else LOAD.
REQ-032 DONE: done=1 one cycle, then IDLE; cur_indx holds final count.
REQ-033 start and ld_en while busy are ignored; memory is write-protected during a run.
REQ-034 Latched num_cmds is used for the whole run; num_cmds changes mid-run have no effect.

Reset
REQ-035 rst (sampled high) forces IDLE, snd_cmd=0, cmd=0, busy=0, done=0, err=0, err_cnt=0, cur_indx=0, timeout counter 0, from any state including mid-run.
REQ-036 Memory contents are not cleared by reset.

Configuration
REQ-037 Macro CMD_SEQ_ABORT_EN defined: first error goes to DONE instead of NEXT; cur_indx frozen at failing index; err_cnt=1.
REQ-038 Macro undefined: errors are counted and the run continues through all num_cmds entries.

Verification
REQ-039 Load {1,0000},{0,4022}; num_cmds=2, tmo=1000; cmd_snt after 50 cycles each, resp A5 after cmd 0 -> two snd_cmd pulses, done, err=0, cur_indx=2.
REQ-040 Entry {1,2002}, resp 8'h5A -> err=1, err_cnt=1, done pulse.
REQ-041 tmo=100, cmd_snt never asserted, 3 entries -> done after ~3x103 cycles, err_cnt=3 (macro undefined); err_cnt=1, cur_indx=0 (macro defined).
REQ-042 num_cmds=0, start -> done 1 cycle later, no snd_cmd, busy pulse only in DONE.
REQ-043 rst asserted in WAIT_RESP -> next cycle all outputs at reset values; new start re-runs from index 0.
REQ-044 ld_en to address 0 with 17'h133F1 during a run -> memory unchanged; after run, write succeeds and next run sends 16'h33F1.
